qrs_track_fsm: RTL

Parametrised R-peak tracking controller for the ECG QRS detection pipeline. It sits after the short-window abs-diff/maximum stage and the extremum finder, and supplies the QRS search enable and adaptive threshold back to them. It replaces the single-mode threshold FSM with several additions:
- configurable learning length and threshold smoothing;
- a post-beat refractory window;
- an N-beat running RR average;
- a missed-beat threshold relaxation (searchback).

---
 rtl/qrs_track_fsm.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/qrs_track_fsm.sv
// rtl/qrs_track_fsm.sv - R-peak tracking controller: learning, adaptive threshold, RR averaging, searchback
module qrs_track_fsm #(
    parameter int DATA_WIDTH  = 11,
    parameter int CTR_WIDTH   = 24,
    parameter int INIT_LEN    = 1080,
    parameter int TH_SHIFT    = 5,
    parameter int RR_DEPTH    = 8,
    parameter int REFRACT_LEN = 72
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_ce,
    input  logic [CTR_WIDTH-1:0]  i_ctr,
    input  logic [DATA_WIDTH-1:0] i_amp,
    input  logic                  i_amp_valid,
    input  logic                  i_extremum_found,
    output logic                  o_qrs_search_en,
    output logic [DATA_WIDTH-1:0] o_qrs_threshold,
    output logic [CTR_WIDTH-1:0]  o_r_peak_sample_num,
    output logic [DATA_WIDTH-1:0] o_rr_period,
    output logic [DATA_WIDTH-1:0] o_rr_avg,
    output logic                  o_rr_valid,
    output logic                  o_beat_strobe,
    output logic                  o_missed_beat
);

    localparam int RR_LOG = $clog2(RR_DEPTH);
    localparam int SUM_W  = DATA_WIDTH + RR_LOG;
    localparam int LC_W   = $clog2(INIT_LEN + 1);
    localparam int RC_W   = $clog2(REFRACT_LEN + 1);
    localparam logic [DATA_WIDTH-1:0] DMAX = {DATA_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_LEARN, S_TH_INIT, S_SEARCH, S_UPD_TH, S_UPD_RR, S_REFRACT
    } state_t;

    state_t                state_q, state_d;
    logic [LC_W-1:0]       learn_cnt_q, learn_cnt_d;
    logic [DATA_WIDTH-1:0] learn_max_q, learn_max_d;
    logic [DATA_WIDTH-1:0] th_q, th_d;
    logic [DATA_WIDTH-1:0] peak_amp_q, peak_amp_d;
    logic [CTR_WIDTH-1:0]  peak_ctr_q, peak_ctr_d;
    logic [CTR_WIDTH-1:0]  r_peak_q, r_peak_d;
    logic                  have_prev_q, have_prev_d;
    logic [DATA_WIDTH-1:0] rr_period_q, rr_period_d;
    logic [DATA_WIDTH-1:0] rr_hist_q [RR_DEPTH];
    logic [DATA_WIDTH-1:0] rr_hist_d [RR_DEPTH];
    logic [RR_LOG-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SUM_W-1:0]      rr_sum_q, rr_sum_d;
    logic [DATA_WIDTH-1:0] rr_avg_q, rr_avg_d;
    logic                  rr_valid_q, rr_valid_d;
    logic                  missed_q, missed_d;
    logic [RC_W-1:0]       refr_cnt_q, refr_cnt_d;
    logic                  strobe_q, strobe_d;

    logic [DATA_WIDTH:0]   th_upd_raw;
    logic [DATA_WIDTH-1:0] th_upd;
    logic [DATA_WIDTH-1:0] th_half;
    logic [DATA_WIDTH-1:0] learn_half;
    logic [CTR_WIDTH-1:0]  rr_raw;
    logic [DATA_WIDTH-1:0] rr_sat;
    logic [CTR_WIDTH-1:0]  since_peak;
    logic [DATA_WIDTH:0]   sb_limit;
    logic                  sb_trigger;

    // Leaky-integrator threshold update; (peak>>A)>>1 folds into a single shift.
    assign th_upd_raw = {1'b0, th_q}
                      - (DATA_WIDTH+1)'(th_q >> TH_SHIFT)
                      + (DATA_WIDTH+1)'(peak_amp_q >> (TH_SHIFT + 1));
    assign th_upd = (th_upd_raw > {1'b0, DMAX}) ? DMAX :
                    (th_upd_raw == '0) ? DATA_WIDTH'(1) : th_upd_raw[DATA_WIDTH-1:0];
    assign th_half    = (th_q[DATA_WIDTH-1:1] == '0) ? DATA_WIDTH'(1) : {1'b0, th_q[DATA_WIDTH-1:1]};
    assign learn_half = (learn_max_q[DATA_WIDTH-1:1] == '0) ? DATA_WIDTH'(1)
                                                            : {1'b0, learn_max_q[DATA_WIDTH-1:1]};

    // Modular subtraction keeps intervals correct across global counter wrap.
    assign rr_raw     = peak_ctr_q - r_peak_q;
    assign rr_sat     = (rr_raw > CTR_WIDTH'(DMAX)) ? DMAX : rr_raw[DATA_WIDTH-1:0];
    assign since_peak = i_ctr - r_peak_q;
    assign sb_limit   = {1'b0, rr_avg_q} + {2'b00, rr_avg_q[DATA_WIDTH-1:1]};
    assign sb_trigger = rr_valid_q && !missed_q && (since_peak > CTR_WIDTH'(sb_limit));

    always_comb begin
        state_d     = state_q;
        learn_cnt_d = learn_cnt_q;
        learn_max_d = learn_max_q;
        th_d        = th_q;
        peak_amp_d  = peak_amp_q;
        peak_ctr_d  = peak_ctr_q;
        r_peak_d    = r_peak_q;
        have_prev_d = have_prev_q;
        rr_period_d = rr_period_q;
        rr_hist_d   = rr_hist_q;
        rr_ptr_d    = rr_ptr_q;
        rr_sum_d    = rr_sum_q;
        rr_valid_d  = rr_valid_q;
        missed_d    = missed_q;
        refr_cnt_d  = refr_cnt_q;
        strobe_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_amp_valid) begin
                    state_d     = S_LEARN;
                    learn_cnt_d = '0;
                    learn_max_d = '0;
                end
            end
            S_LEARN: begin
                learn_cnt_d = learn_cnt_q + LC_W'(1);
                if (i_amp_valid && (i_amp > learn_max_q)) learn_max_d = i_amp;
                if (learn_cnt_q == LC_W'(INIT_LEN - 1)) state_d = S_TH_INIT;
            end
            S_TH_INIT: begin
                th_d    = learn_half;
                state_d = S_SEARCH;
            end
            S_SEARCH: begin
                if (i_extremum_found) begin
                    peak_amp_d = i_amp;
                    peak_ctr_d = i_ctr;
                    state_d    = S_UPD_TH;
                end else if (sb_trigger) begin
                    th_d     = th_half;
                    missed_d = 1'b1;
                end
            end
            S_UPD_TH: begin
                th_d    = th_upd;
                state_d = S_UPD_RR;
            end
            S_UPD_RR: begin
                r_peak_d = peak_ctr_q;
                if (have_prev_q) begin
                    rr_period_d = rr_sat;
                    rr_valid_d  = 1'b1;
                    if (!rr_valid_q) begin
                        for (int i = 0; i < RR_DEPTH; i++) rr_hist_d[i] = rr_sat;
                        rr_sum_d = SUM_W'(rr_sat) << RR_LOG;
                    end else begin
                        rr_hist_d[rr_ptr_q] = rr_sat;
                        rr_sum_d = rr_sum_q + SUM_W'(rr_sat) - SUM_W'(rr_hist_q[rr_ptr_q]);
                        rr_ptr_d = rr_ptr_q + RR_LOG'(1);
                    end
                end
                have_prev_d = 1'b1;
                missed_d    = 1'b0;
                refr_cnt_d  = '0;
                strobe_d    = 1'b1;
                state_d     = S_REFRACT;
            end
            S_REFRACT: begin
                if (refr_cnt_q == RC_W'(REFRACT_LEN - 1)) state_d = S_SEARCH;
                else refr_cnt_d = refr_cnt_q + RC_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        rr_avg_d = rr_sum_d[SUM_W-1:RR_LOG];
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q     <= S_IDLE;
            learn_cnt_q <= '0;
            learn_max_q <= '0;
            th_q        <= '0;
            peak_amp_q  <= '0;
            peak_ctr_q  <= '0;
            r_peak_q    <= '0;
            have_prev_q <= 1'b0;
            rr_period_q <= '0;
            for (int i = 0; i < RR_DEPTH; i++) rr_hist_q[i] <= '0;
            rr_ptr_q    <= '0;
            rr_sum_q    <= '0;
            rr_avg_q    <= '0;
            rr_valid_q  <= 1'b0;
            missed_q    <= 1'b0;
            refr_cnt_q  <= '0;
            strobe_q    <= 1'b0;
        end else if (i_ce) begin
            state_q     <= state_d;
            learn_cnt_q <= learn_cnt_d;
            learn_max_q <= learn_max_d;
            th_q        <= th_d;
            peak_amp_q  <= peak_amp_d;
            peak_ctr_q  <= peak_ctr_d;
            r_peak_q    <= r_peak_d;
            have_prev_q <= have_prev_d;
            rr_period_q <= rr_period_d;
            rr_hist_q   <= rr_hist_d;
            rr_ptr_q    <= rr_ptr_d;
            rr_sum_q    <= rr_sum_d;
            rr_avg_q    <= rr_avg_d;
            rr_valid_q  <= rr_valid_d;
            missed_q    <= missed_d;
            refr_cnt_q  <= refr_cnt_d;
            strobe_q    <= strobe_d;
        end
    end

    assign o_qrs_search_en     = (state_q == S_SEARCH);
    assign o_qrs_threshold     = th_q;
    assign o_r_peak_sample_num = r_peak_q;
    assign o_rr_period         = rr_period_q;
    assign o_rr_avg            = rr_avg_q;
    assign o_rr_valid          = rr_valid_q;
    assign o_beat_strobe       = strobe_q;
    assign o_missed_beat       = missed_q;

endmodule
